// File: rtl/csc_ctrl_pkg.sv
// Shared types and constants for the CSC column read controller.
package csc_ctrl_pkg;

  localparam int unsigned CSC_ADDR_W         = 7;
  localparam int unsigned CSC_IDX_W          = 5;
  localparam int unsigned CSC_EMPTY_SENTINEL = 127;
  localparam int unsigned CSC_END_MARK       = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_START,
    ST_RD_END,
    ST_CAP_END,
    ST_STREAM,
    ST_DONE
  } csc_state_e;

  // Outcome of inspecting a column's start/end pointer pair.
  typedef enum logic [1:0] {
    CLS_STREAM,
    CLS_EMPTY,
    CLS_ERR
  } csc_class_e;

endpackage

// File: rtl/csc_column_read_ctrl.sv
// Fetches one CSC column's start/end pointers from the address spad and streams
// the column's data-spad pointers to the consumer under valid/ready.
module csc_column_read_ctrl
  import csc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = CSC_ADDR_W,
  parameter int unsigned IDX_W  = CSC_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              col_req_valid_i,
  output logic              col_req_ready_o,
  input  logic [IDX_W-1:0]  col_req_idx_i,
  output logic [IDX_W-1:0]  spad_read_idx_o,
  output logic              spad_read_idx_en_o,
  input  logic [ADDR_W-1:0] spad_addr_data_i,
  output logic              ptr_valid_o,
  input  logic              ptr_ready_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              ptr_last_o,
  output logic              col_done_o,
  output logic              col_empty_o,
  output logic              col_err_o,
  input  logic              abort_i
);

  localparam logic [ADDR_W-1:0] SENTINEL = ADDR_W'(CSC_EMPTY_SENTINEL);
  localparam logic [ADDR_W-1:0] END_MARK = ADDR_W'(CSC_END_MARK);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [IDX_W-1:0]  ONE_I    = IDX_W'(1);

  csc_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] cur_q, cur_d;

  logic              req_ready_q, req_ready_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rd_en_q, rd_en_d;
  logic              ptr_valid_q, ptr_valid_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ptr_last_q, ptr_last_d;
  logic              done_q, done_d;
  logic              empty_q, empty_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] cur_inc;
  logic [ADDR_W-1:0] end_m1;
  logic [ADDR_W-1:0] spad_m1;
  logic              first_col;
  csc_class_e        cls;

  assign cur_inc   = cur_q + ONE_A;
  assign end_m1    = end_q - ONE_A;
  assign spad_m1   = spad_addr_data_i - ONE_A;
  assign first_col = (idx_q == '0);

  // Column 0 has an implicit start of 0, so only its end pointer is vetted.
  // END_MARK outranks the ordering check: a zero end means past-the-matrix, not corruption.
  always_comb begin
    cls = CLS_STREAM;
    if ((spad_addr_data_i == SENTINEL) || (!first_col && (start_q == SENTINEL))) begin
      cls = CLS_ERR;
    end else if (spad_addr_data_i == END_MARK) begin
      cls = CLS_EMPTY;
    end else if (!first_col && (spad_addr_data_i < start_q)) begin
      cls = CLS_ERR;
    end else if (spad_addr_data_i == start_q) begin
      cls = CLS_EMPTY;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_d     = start_q;
    end_d       = end_q;
    cur_d       = cur_q;
    req_ready_d = 1'b0;
    rd_idx_d    = '0;
    rd_en_d     = 1'b0;
    ptr_valid_d = 1'b0;
    ptr_d       = '0;
    ptr_last_d  = 1'b0;
    done_d      = 1'b0;
    empty_d     = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (col_req_valid_i) begin
          idx_d   = col_req_idx_i;
          rd_en_d = 1'b1;
          if (col_req_idx_i == '0) begin
            start_d  = '0;
            rd_idx_d = '0;
            state_d  = ST_RD_END;
          end else begin
            rd_idx_d = col_req_idx_i - ONE_I;
            state_d  = ST_RD_START;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_RD_START: begin
        rd_idx_d = idx_q;
        rd_en_d  = 1'b1;
        state_d  = ST_RD_END;
      end

      ST_RD_END: begin
        // Spad now presents entry idx-1 (the start pointer) for nonzero columns.
        if (!first_col) begin
          start_d = spad_addr_data_i;
        end
        state_d = ST_CAP_END;
      end

      ST_CAP_END: begin
        end_d = spad_addr_data_i;
        cur_d = start_q;
        unique case (cls)
          CLS_ERR: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
          CLS_EMPTY: begin
            done_d  = 1'b1;
            empty_d = 1'b1;
            state_d = ST_DONE;
          end
          default: begin
            ptr_valid_d = 1'b1;
            ptr_d       = start_q;
            ptr_last_d  = (start_q == spad_m1);
            state_d     = ST_STREAM;
          end
        endcase
      end

      ST_STREAM: begin
        if (ptr_ready_i) begin
          if (ptr_last_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cur_d       = cur_inc;
            ptr_valid_d = 1'b1;
            ptr_d       = cur_inc;
            ptr_last_d  = (cur_inc == end_m1);
          end
        end else begin
          ptr_valid_d = 1'b1;
          ptr_d       = ptr_q;
          ptr_last_d  = ptr_last_q;
        end
      end

      ST_DONE: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase

    // Flush overrides everything, including a request arriving in IDLE.
    if (abort_i) begin
      state_d     = ST_IDLE;
      req_ready_d = 1'b1;
      rd_idx_d    = '0;
      rd_en_d     = 1'b0;
      ptr_valid_d = 1'b0;
      ptr_d       = '0;
      ptr_last_d  = 1'b0;
      done_d      = 1'b0;
      empty_d     = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      cur_q       <= '0;
      req_ready_q <= 1'b1;
      rd_idx_q    <= '0;
      rd_en_q     <= 1'b0;
      ptr_valid_q <= 1'b0;
      ptr_q       <= '0;
      ptr_last_q  <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      end_q       <= end_d;
      cur_q       <= cur_d;
      req_ready_q <= req_ready_d;
      rd_idx_q    <= rd_idx_d;
      rd_en_q     <= rd_en_d;
      ptr_valid_q <= ptr_valid_d;
      ptr_q       <= ptr_d;
      ptr_last_q  <= ptr_last_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
      err_q       <= err_d;
    end
  end

  assign col_req_ready_o    = req_ready_q;
  assign spad_read_idx_o    = rd_idx_q;
  assign spad_read_idx_en_o = rd_en_q;
  assign ptr_valid_o        = ptr_valid_q;
  assign ptr_o              = ptr_q;
  assign ptr_last_o         = ptr_last_q;
  assign col_done_o         = done_q;
  assign col_empty_o        = empty_q;
  assign col_err_o          = err_q;

endmodule

// File: tb/tb_csc_column_read_ctrl.sv
// Bench for csc_column_read_ctrl: directed vector table, corner sequences and
// randomized columns checked against a pointer-list reference model.
module tb_csc_column_read_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       col_req_valid_i;
  logic       col_req_ready_o;
  logic [4:0] col_req_idx_i;
  logic [4:0] spad_read_idx_o;
  logic       spad_read_idx_en_o;
  logic [6:0] spad_addr_data_i;
  logic       ptr_valid_o;
  logic       ptr_ready_i;
  logic [6:0] ptr_o;
  logic       ptr_last_o;
  logic       col_done_o;
  logic       col_empty_o;
  logic       col_err_o;
  logic       abort_i;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] mem [32];
  logic [6:0] rd_q;

  csc_column_read_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .col_req_valid_i    (col_req_valid_i),
    .col_req_ready_o    (col_req_ready_o),
    .col_req_idx_i      (col_req_idx_i),
    .spad_read_idx_o    (spad_read_idx_o),
    .spad_read_idx_en_o (spad_read_idx_en_o),
    .spad_addr_data_i   (spad_addr_data_i),
    .ptr_valid_o        (ptr_valid_o),
    .ptr_ready_i        (ptr_ready_i),
    .ptr_o              (ptr_o),
    .ptr_last_o         (ptr_last_o),
    .col_done_o         (col_done_o),
    .col_empty_o        (col_empty_o),
    .col_err_o          (col_err_o),
    .abort_i            (abort_i)
  );

  always #5 clk = ~clk;

  // Address spad: registered read, data visible after the loading edge.
  always_ff @(posedge clk) begin
    if (spad_read_idx_en_o) rd_q <= mem[spad_read_idx_o];
  end
  assign spad_addr_data_i = rd_q;

  typedef struct {
    int col;
    int mem_set;
    int mode;
    int exp_first;
    int exp_n;
    bit exp_empty;
    bit exp_err;
    int exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_mem(input int s);
    for (int i = 0; i < 32; i++) mem[i] = 7'd127;
    if (s == 0) begin
      mem[0] = 7'd3; mem[1] = 7'd5; mem[2] = 7'd5; mem[3] = 7'd9; mem[4] = 7'd0;
    end else if (s == 2) begin
      mem[0] = 7'd6; mem[1] = 7'd2;
    end
  endtask

  // Reference: column c spans [start, end) with start = 0 for c = 0.
  task automatic model(input int col, output int first, output int n,
                       output bit emp, output bit err);
    int s;
    int e;
    s = (col == 0) ? 0 : int'(mem[col-1]);
    e = int'(mem[col]);
    first = s; n = 0; emp = 0; err = 0;
    if (e == 127 || (col != 0 && s == 127)) err = 1;
    else if (e == 0) emp = 1;
    else if (e < s) err = 1;
    else if (e == s) emp = 1;
    else n = e - s;
  endtask

  // mode 0: always ready, 1: fixed toggle pattern, 2: random ready.
  task automatic run_col(input int col, input int mode, input int exp_first, input int exp_n,
                         input bit exp_empty, input bit exp_err, input int exp_lat);
    int c, first_c, done_c, k, lat;
    bit prev_stall, r, got_emp, got_err;
    logic [6:0] prev_ptr;
    logic prev_last;
    int got_ptr[$];
    bit got_last[$];
    bit pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    chk("req_ready_idle", col_req_ready_o, 1);
    col_req_valid_i = 1'b1;
    col_req_idx_i   = 5'(col);
    @(negedge clk);
    col_req_valid_i = 1'b0;
    chk("req_ready_busy", col_req_ready_o, 0);
    c = 0; first_c = -1; done_c = -1; k = 0; prev_stall = 0;
    got_emp = 0; got_err = 0; prev_ptr = '0; prev_last = 1'b0;
    while (done_c < 0 && c < 400) begin
      if (prev_stall) begin
        chk("stall_valid", ptr_valid_o, 1);
        chk("stall_ptr", ptr_o, prev_ptr);
        chk("stall_last", ptr_last_o, prev_last);
      end
      prev_stall = 0;
      if (ptr_valid_o) begin
        if (first_c < 0) first_c = c;
        case (mode)
          0:       r = 1'b1;
          1:       r = (k < 7) ? pat[k] : 1'b1;
          default: r = ($urandom_range(0, 3) != 0);
        endcase
        k++;
        if (r) begin
          got_ptr.push_back(int'(ptr_o));
          got_last.push_back(ptr_last_o);
        end else begin
          prev_stall = 1; prev_ptr = ptr_o; prev_last = ptr_last_o;
        end
        ptr_ready_i = r;
      end else begin
        ptr_ready_i = 1'b0;
      end
      if (col_done_o) begin
        done_c = c; got_emp = col_empty_o; got_err = col_err_o;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    ptr_ready_i = 1'b0;
    if (done_c < 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("n_ptrs", got_ptr.size(), exp_n);
    for (int i = 0; i < got_ptr.size(); i++) begin
      chk("ptr_value", got_ptr[i], exp_first + i);
      chk("ptr_last", got_last[i], (i == exp_n - 1));
    end
    chk("col_empty", got_emp, exp_empty);
    chk("col_err", got_err, exp_err);
    lat = (exp_n > 0) ? first_c + 1 : done_c + 1;
    chk("latency", lat, exp_lat);
    @(negedge clk);
    chk("done_one_cycle", col_done_o, 0);
    chk("ready_after_done", col_req_ready_o, 1);
  endtask

  vec_t vecs [8];

  initial begin
    int first, n, lat, hit;
    bit emp, err;

    vecs[0] = '{1, 0, 0, 3, 2, 1'b0, 1'b0, 4};
    vecs[1] = '{0, 0, 0, 0, 3, 1'b0, 1'b0, 3};
    vecs[2] = '{2, 0, 0, 0, 0, 1'b1, 1'b0, 4};
    vecs[3] = '{4, 0, 0, 0, 0, 1'b1, 1'b0, 4};
    vecs[4] = '{3, 1, 0, 0, 0, 1'b0, 1'b1, 4};
    vecs[5] = '{1, 2, 0, 0, 0, 1'b0, 1'b1, 4};
    vecs[6] = '{3, 0, 1, 5, 4, 1'b0, 1'b0, 4};
    vecs[7] = '{0, 1, 0, 0, 0, 1'b0, 1'b1, 3};

    rst_n = 1'b0; col_req_valid_i = 1'b0; col_req_idx_i = '0;
    ptr_ready_i = 1'b0; abort_i = 1'b0;
    set_mem(0);
    @(negedge clk); @(negedge clk);
    chk("rst_ready", col_req_ready_o, 1);
    chk("rst_rd_en", spad_read_idx_en_o, 0);
    chk("rst_ptr_valid", ptr_valid_o, 0);
    chk("rst_done", col_done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      set_mem(vecs[i].mem_set);
      run_col(vecs[i].col, vecs[i].mode, vecs[i].exp_first, vecs[i].exp_n,
              vecs[i].exp_empty, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Abort mid-stream once pointer 6 is presented.
    set_mem(0);
    col_req_valid_i = 1'b1; col_req_idx_i = 5'd3;
    @(negedge clk);
    col_req_valid_i = 1'b0;
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      if (ptr_valid_o && ptr_o == 7'd6) hit = 1;
      else begin
        ptr_ready_i = 1'b1;
        @(negedge clk);
      end
    end
    chk("abort_reach_ptr6", hit, 1);
    abort_i = 1'b1; ptr_ready_i = 1'b0;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_valid_low", ptr_valid_o, 0);
    chk("abort_ready", col_req_ready_o, 1);
    chk("abort_no_done", col_done_o, 0);
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (col_done_o || ptr_valid_o) hit = 1;
    end
    chk("abort_quiet", hit, 0);

    // Abort coinciding with a request in IDLE: request is dropped.
    col_req_valid_i = 1'b1; abort_i = 1'b1; col_req_idx_i = 5'd1;
    @(negedge clk);
    col_req_valid_i = 1'b0; abort_i = 1'b0;
    chk("abort_req_ready", col_req_ready_o, 1);
    chk("abort_req_rd_en", spad_read_idx_en_o, 0);
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (col_done_o || ptr_valid_o || !col_req_ready_o) hit = 1;
    end
    chk("abort_req_ignored", hit, 0);

    // Async reset while the end pointer is being read.
    col_req_valid_i = 1'b1; col_req_idx_i = 5'd1;
    @(negedge clk);
    col_req_valid_i = 1'b0;
    @(negedge clk);
    chk("rd_end_en", spad_read_idx_en_o, 1);
    chk("rd_end_idx", spad_read_idx_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ready", col_req_ready_o, 1);
    chk("async_rd_en", spad_read_idx_en_o, 0);
    chk("async_rd_idx", spad_read_idx_o, 0);
    chk("async_valid", ptr_valid_o, 0);
    chk("async_done", col_done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_col(1, 0, 3, 2, 1'b0, 1'b0, 4);

    // Randomized columns against the reference model.
    for (int t = 0; t < 40; t++) begin
      int p;
      p = $urandom_range(0, 4);
      for (int i = 0; i < 32; i++) begin
        p += $urandom_range(0, 3);
        mem[i] = (p > 126) ? 7'd126 : 7'(p);
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       mem[$urandom_range(0, 31)] = 7'd127;
          1:       mem[$urandom_range(0, 31)] = 7'd0;
          default: mem[$urandom_range(0, 31)] = 7'($urandom_range(0, 126));
        endcase
      end
      begin
        int col;
        col = $urandom_range(0, 31);
        model(col, first, n, emp, err);
        lat = (col == 0) ? 3 : 4;
        run_col(col, 2, first, n, emp, err, lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
